icon_tx_arbiter: RTL and testbench

//  Round-robin arbiter sharing one interconnect (icon) tx channel among NUM_EU ALPU tx ports.

---
 rtl/icon_tx_arbiter.sv | 110 +++++++++++
 tb/tb_icon_tx_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/icon_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : icon_tx_arbiter
// Description : Round-robin arbiter that shares one icon tx channel among
//               NUM_EU ALPU tx ports through a 1-deep registered output slot
//               with a valid/ready handshake on the icon side.
// Ports       : i_clk, i_reset       - clock, synchronous active-high reset
//               i_req_valid/addr/data - per-EU operand requests (packed buses)
//               o_req_ready           - one-hot accept strobe back to the EUs
//               o_tx_valid/addr/data  - icon channel beat
//               o_tx_src              - index of the EU that sourced the beat
//               i_tx_ready            - icon rx ready
//               o_grant_cnt           - saturating count of accepted beats
// Revision    : 1.0 - initial release
// ============================================================================
module icon_tx_arbiter #(
  parameter int NUM_EU       = 4,
  parameter int LOG2_NUM_EU  = $clog2(NUM_EU),
  parameter int LOG2_NUM_REG = 3,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 1 + LOG2_NUM_EU + LOG2_NUM_REG
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NUM_EU-1:0]            i_req_valid,
  input  logic [NUM_EU*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_EU*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_EU-1:0]            o_req_ready,
  output logic                         o_tx_valid,
  output logic [ADDR_WIDTH-1:0]        o_tx_addr,
  output logic [DATA_WIDTH-1:0]        o_tx_data,
  output logic [LOG2_NUM_EU-1:0]       o_tx_src,
  input  logic                         i_tx_ready,
  output logic [15:0]                  o_grant_cnt
);

  logic [LOG2_NUM_EU-1:0] rr_ptr;
  logic [LOG2_NUM_EU-1:0] grant;
  logic [LOG2_NUM_EU-1:0] hi_grant;
  logic [LOG2_NUM_EU-1:0] lo_grant;
  logic                   hi_any;
  logic                   any_req;
  logic                   load;
  logic                   accept;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Round-robin search split in two passes: the lowest requester at or above
  // rr_ptr wins; if none exists, the lowest requester overall (the wrap).
  // Scanning downward lets the last hit be the lowest index. This avoids
  // modulo arithmetic so non-power-of-two NUM_EU wraps correctly.
  always_comb begin
    hi_any   = 1'b0;
    hi_grant = '0;
    lo_grant = '0;
    for (int k = NUM_EU - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        lo_grant = LOG2_NUM_EU'(k);
        if (k >= int'(rr_ptr)) begin
          hi_any   = 1'b1;
          hi_grant = LOG2_NUM_EU'(k);
        end
      end
    end
    grant = hi_any ? hi_grant : lo_grant;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_EU; k++) begin
      if (grant == LOG2_NUM_EU'(k)) begin
        sel_addr = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The slot can take a new beat when it is empty or being drained this cycle.
  assign any_req     = |i_req_valid;
  assign load        = !o_tx_valid || i_tx_ready;
  assign accept      = load && any_req && !i_reset;
  assign o_req_ready = accept ? (NUM_EU'(1) << grant) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tx_valid  <= 1'b0;
      o_tx_addr   <= '0;
      o_tx_data   <= '0;
      o_tx_src    <= '0;
      rr_ptr      <= '0;
      o_grant_cnt <= '0;
    end else if (accept) begin
      o_tx_valid <= 1'b1;
      o_tx_addr  <= sel_addr;
      o_tx_data  <= sel_data;
      o_tx_src   <= grant;
      rr_ptr     <= (grant == LOG2_NUM_EU'(NUM_EU - 1)) ? '0
                                                        : grant + LOG2_NUM_EU'(1);
      if (o_grant_cnt != 16'hFFFF) begin
        o_grant_cnt <= o_grant_cnt + 16'd1;
      end
    end else if (load) begin
      // Slot drained (or was already empty) with nothing to refill it.
      o_tx_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icon_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_icon_tx_arbiter
// Description : Self-checking bench for icon_tx_arbiter. A 4-EU instance is
//               driven from a table of directed per-cycle vectors; a 3-EU
//               instance is run continuously to cover non-power-of-two
//               wrapping and grant counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icon_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- 4-EU instance ----------------
  logic        rst4;
  logic [3:0]  valid4;
  logic [23:0] addr4;
  logic [63:0] data4;
  logic [3:0]  ready4;
  logic        txv4;
  logic [5:0]  txa4;
  logic [15:0] txd4;
  logic [1:0]  src4;
  logic        txr4;
  logic [15:0] cnt4;

  icon_tx_arbiter #(.NUM_EU(4), .DATA_WIDTH(16)) dut (
    .i_clk(clk), .i_reset(rst4), .i_req_valid(valid4), .i_req_addr(addr4),
    .i_req_data(data4), .o_req_ready(ready4), .o_tx_valid(txv4), .o_tx_addr(txa4),
    .o_tx_data(txd4), .o_tx_src(src4), .i_tx_ready(txr4), .o_grant_cnt(cnt4)
  );

  logic [5:0]  eu_addr [4];
  logic [15:0] eu_data [4];

  // ---------------- 3-EU instance ----------------
  logic        rst3;
  logic [2:0]  valid3;
  logic [17:0] addr3;
  logic [47:0] data3;
  logic [2:0]  ready3;
  logic        txv3;
  logic [5:0]  txa3;
  logic [15:0] txd3;
  logic [1:0]  src3;
  logic        txr3;
  logic [15:0] cnt3;

  icon_tx_arbiter #(.NUM_EU(3), .DATA_WIDTH(16)) dut3 (
    .i_clk(clk), .i_reset(rst3), .i_req_valid(valid3), .i_req_addr(addr3),
    .i_req_data(data3), .o_req_ready(ready3), .o_tx_valid(txv3), .o_tx_addr(txa3),
    .o_tx_data(txd3), .o_tx_src(src3), .i_tx_ready(txr3), .o_grant_cnt(cnt3)
  );

  // One row = inputs applied for one cycle, the expected combinational ready
  // during that cycle, and the expected registered state after the edge.
  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       txr;
    logic [3:0] ready;
    logic       txv;
    int         src;
    int         cnt;
    int         ptr;
    logic       slot;   // 1: slot holds beat of EU src; 0: slot cleared
  } vec_t;

  vec_t vecs[$];

  initial begin
    eu_addr[0] = 6'h21; eu_addr[1] = 6'h0A; eu_addr[2] = 6'h33; eu_addr[3] = 6'h1C;
    eu_data[0] = 16'h1111; eu_data[1] = 16'h2222; eu_data[2] = 16'hBEEF; eu_data[3] = 16'h4444;
    addr4 = {eu_addr[3], eu_addr[2], eu_addr[1], eu_addr[0]};
    data4 = {eu_data[3], eu_data[2], eu_data[1], eu_data[0]};
    rst4 = 1'b1; valid4 = '0; txr4 = 1'b1;
    rst3 = 1'b1; valid3 = '0; txr3 = 1'b1;
    addr3 = {6'h25, 6'h12, 6'h08};
    data3 = {16'hC003, 16'hC002, 16'hC001};

    //                rst  valid   txr  ready   txv src cnt ptr slot
    // reset
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0, 0, 1'b0});
    // single request from EU2
    vecs.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 1, 3, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2, 1, 3, 1'b1});
    // all requesting, back-to-back rotation from rr_ptr=3
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3, 2, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 3, 1, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 4, 2, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2, 5, 3, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3, 6, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 7, 1, 1'b1});
    // EU1 beat, held under backpressure for 3 cycles, then drain+reload
    vecs.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 1, 8, 2, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1, 8, 2, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1, 8, 2, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1, 8, 2, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 1, 9, 2, 1'b1});
    // move rr_ptr to 3, then EU0/EU3 only: 3, 0, 3
    vecs.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 10, 3, 1'b1});
    vecs.push_back('{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 3, 11, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 0, 12, 1, 1'b1});
    vecs.push_back('{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 3, 13, 0, 1'b1});
    // stalled beat, then reset mid-transfer
    vecs.push_back('{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 3, 13, 0, 1'b1});
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 0, 0, 0, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1, 1, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1, 1, 1'b1});

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst4   = vecs[i].rst;
      valid4 = vecs[i].valid;
      txr4   = vecs[i].txr;
      #1;
      check($sformatf("ready[%0d]", i), 32'(ready4), 32'(vecs[i].ready));
      @(posedge clk); #1;
      check($sformatf("tx_valid[%0d]", i), 32'(txv4), 32'(vecs[i].txv));
      check($sformatf("tx_src[%0d]", i), 32'(src4), 32'(vecs[i].src));
      check($sformatf("grant_cnt[%0d]", i), 32'(cnt4), 32'(vecs[i].cnt));
      check($sformatf("rr_ptr[%0d]", i), 32'(dut.rr_ptr), 32'(vecs[i].ptr));
      if (vecs[i].slot) begin
        check($sformatf("tx_addr[%0d]", i), 32'(txa4), 32'(eu_addr[vecs[i].src]));
        check($sformatf("tx_data[%0d]", i), 32'(txd4), 32'(eu_data[vecs[i].src]));
      end else begin
        check($sformatf("tx_addr[%0d]", i), 32'(txa4), 32'd0);
        check($sformatf("tx_data[%0d]", i), 32'(txd4), 32'd0);
      end
    end

    // ---- 3-EU: continuous requests, wrap 2->0, saturation after 70000 beats
    rst3 = 1'b1; valid3 = 3'b111; txr3 = 1'b1;
    @(posedge clk); #1;
    check("nu3_reset_cnt", 32'(cnt3), 32'd0);
    check("nu3_reset_valid", 32'(txv3), 32'd0);
    rst3 = 1'b0;
    begin
      int bad_src;
      int bad_ptr;
      int bad_cnt;
      int exp_cnt;
      bad_src = 0; bad_ptr = 0; bad_cnt = 0;
      for (int n = 1; n <= 70000; n++) begin
        @(posedge clk); #1;
        exp_cnt = (n > 65535) ? 65535 : n;
        if (n <= 6) begin
          check($sformatf("nu3_src[%0d]", n), 32'(src3), 32'((n - 1) % 3));
          check($sformatf("nu3_valid[%0d]", n), 32'(txv3), 32'd1);
        end
        if (int'(src3) != (n - 1) % 3 || txv3 !== 1'b1) bad_src++;
        if (int'(dut3.rr_ptr) > 2 || int'(dut3.rr_ptr) != n % 3) bad_ptr++;
        if (int'(cnt3) != exp_cnt) bad_cnt++;
        if (n == 65534) check("nu3_cnt_65534", 32'(cnt3), 32'h0000FFFE);
        if (n == 65535) check("nu3_cnt_65535", 32'(cnt3), 32'h0000FFFF);
      end
      check("nu3_src_seq_errors", 32'(bad_src), 32'd0);
      check("nu3_ptr_errors", 32'(bad_ptr), 32'd0);
      check("nu3_cnt_errors", 32'(bad_cnt), 32'd0);
      check("nu3_cnt_saturated", 32'(cnt3), 32'h0000FFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
